stream_fifo_lvl: RTL



---
 rtl/stream_fifo_lvl.sv | 133 +++++++++++++
 1 files changed

// File: rtl/stream_fifo_lvl.sv
// First-word-fall-through stream FIFO with fill level, almost-full/empty flags and flush.
// Write-to-read latency is 1 cycle; s_ready_o drops when full. Define STREAM_FIFO_LVL_PKT_EN for store-and-forward packets.
module stream_fifo_lvl #(
  parameter int DW         = 8,
  parameter int AW         = 4,
  parameter int AFULL_LVL  = (2 ** AW) - 2,
  parameter int AEMPTY_LVL = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush_i,
  input  logic [DW-1:0] s_data_i,
  input  logic          s_valid_i,
  output logic          s_ready_o,
`ifdef STREAM_FIFO_LVL_PKT_EN
  input  logic          s_last_i,
`endif
  output logic [DW-1:0] m_data_o,
  output logic          m_valid_o,
  input  logic          m_ready_i,
`ifdef STREAM_FIFO_LVL_PKT_EN
  output logic          m_last_o,
`endif
  output logic [AW:0]   fill_o,
  output logic          almost_full_o,
  output logic          almost_empty_o
);

  localparam int DEPTH = 2 ** AW;
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   AF_THR   = (AW+1)'(AFULL_LVL);
  localparam logic [AW:0]   AE_THR   = (AW+1)'(AEMPTY_LVL);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   fill;
  logic [AW:0]   fill_nxt;
  logic          full;
  logic          empty;
  logic          wr_en;
  logic          rd_en;

  assign full      = (fill == FULL_CNT);
  assign empty     = (fill == '0);
  assign s_ready_o = ~full & ~rst & ~flush_i;
  assign wr_en     = s_valid_i & s_ready_o;
  assign rd_en     = m_valid_o & m_ready_i;
  assign fill_o    = fill;
  assign m_data_o  = mem[rd_ptr];

`ifdef STREAM_FIFO_LVL_PKT_EN
  logic          last_mem [DEPTH];
  logic [AW:0]   pkt_cnt;
  logic [AW:0]   pkt_nxt;
  logic          wr_last;
  logic          rd_last;

  // A full FIFO releases its head even without a complete packet, so packets
  // longer than the depth pass through cut-through instead of deadlocking.
  assign m_valid_o = ~empty & ~flush_i & ((pkt_cnt != '0) | full);
  assign m_last_o  = m_valid_o & last_mem[rd_ptr];
  assign wr_last   = wr_en & s_last_i;
  assign rd_last   = rd_en & m_last_o;

  always_comb begin
    pkt_nxt = pkt_cnt;
    if (flush_i)
      pkt_nxt = '0;
    else if (wr_last && !rd_last)
      pkt_nxt = pkt_cnt + CNT_ONE;
    else if (!wr_last && rd_last)
      pkt_nxt = pkt_cnt - CNT_ONE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      pkt_cnt <= '0;
    else
      pkt_cnt <= pkt_nxt;
  end

  always_ff @(posedge clk) begin
    if (wr_en)
      last_mem[wr_ptr] <= s_last_i;
  end
`else
  assign m_valid_o = ~empty & ~flush_i;
`endif

  always_comb begin
    fill_nxt = fill;
    if (flush_i)
      fill_nxt = '0;
    else if (wr_en && !rd_en)
      fill_nxt = fill + CNT_ONE;
    else if (!wr_en && rd_en)
      fill_nxt = fill - CNT_ONE;
  end

  // Flags are derived from fill_nxt so they move on the same edge as fill_o.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      fill           <= '0;
      almost_full_o  <= 1'b0;
      almost_empty_o <= 1'b1;
    end else begin
      if (flush_i) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (wr_en)
          wr_ptr <= wr_ptr + PTR_ONE;
        if (rd_en)
          rd_ptr <= rd_ptr + PTR_ONE;
      end
      fill           <= fill_nxt;
      almost_full_o  <= (fill_nxt >= AF_THR);
      almost_empty_o <= (fill_nxt <= AE_THR);
    end
  end

  // Storage is not reset; flush and reset only move the pointers.
  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wr_ptr] <= s_data_i;
  end

endmodule
